// File: rtl/ppu_vram_pkg.sv
// VRAM region map, client ids and return-tag layout shared by the PPU VRAM read and write paths.
// Latency: none; constants, types and pure functions only.
// Backpressure: not applicable.
package ppu_vram_pkg;

  localparam int VRAM_AW = 13;
  localparam int VRAM_DW = 64;

  typedef enum logic [1:0] {
    CLI_TILE    = 2'd0,
    CLI_PATTERN = 2'd1,
    CLI_PALETTE = 2'd2,
    CLI_SPRITE  = 2'd3
  } cli_e;

  // Word-granular region map (word address = byte address >> 3)
  localparam logic [VRAM_AW-1:0] TILE_BASE    = 13'h0000;
  localparam logic [VRAM_AW-1:0] TILE_SIZE    = 13'h0800;
  localparam logic [VRAM_AW-1:0] PATTERN_BASE = 13'h0800;
  localparam logic [VRAM_AW-1:0] PATTERN_SIZE = 13'h1000;
  localparam logic [VRAM_AW-1:0] PALETTE_BASE = 13'h1800;
  localparam logic [VRAM_AW-1:0] PALETTE_SIZE = 13'h0200;
  localparam logic [VRAM_AW-1:0] SPRITE_BASE  = 13'h1A00;
  localparam logic [VRAM_AW-1:0] SPRITE_SIZE  = 13'h0600;

  // zero=1 marks an out-of-bounds read whose return word is forced to 0
  typedef struct packed {
    logic valid;
    logic zero;
    cli_e cli;
  } rd_tag_t;

  function automatic logic [VRAM_AW-1:0] region_base(input cli_e c);
    case (c)
      CLI_TILE:    return TILE_BASE;
      CLI_PATTERN: return PATTERN_BASE;
      CLI_PALETTE: return PALETTE_BASE;
      default:     return SPRITE_BASE;
    endcase
  endfunction

  function automatic logic [VRAM_AW-1:0] region_size(input cli_e c);
    case (c)
      CLI_TILE:    return TILE_SIZE;
      CLI_PATTERN: return PATTERN_SIZE;
      CLI_PALETTE: return PALETTE_SIZE;
      default:     return SPRITE_SIZE;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter; the pointer names the highest-priority requester.
// Latency: grant is combinational in the request cycle; the pointer updates at that cycle's edge.
// Backpressure: a request is simply held until granted; the pointer holds while nobody requests.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic [1:0] rr_ptr;
  logic [1:0] idx;
  logic       found;

  // Search rr_ptr, rr_ptr+1, ... mod 4 and grant the first requester
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  // Rotate priority past the winner; any request implies a grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (|req) begin
      rr_ptr <= gnt_idx + 2'd1;
    end
  end

endmodule

// File: rtl/vram_rd_arbiter.sv
// Shares the VRAM read port among the tile/pattern/palette/sprite fetchers, relocating and bounds-checking offsets.
// Latency: grant same cycle; rden/rdaddr one cycle later; return strobe 1+RD_LAT cycles after grant.
// Backpressure: requests wait for a grant; returns cannot be stalled and must be taken by the client.
module vram_rd_arbiter
  import ppu_vram_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int NCLI   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NCLI-1:0]                cli_req,
  input  logic [NCLI-1:0][VRAM_AW-1:0]   cli_offset,
  output logic [NCLI-1:0]                cli_gnt,
  output logic [NCLI-1:0]                cli_rvalid,
  output logic [VRAM_DW-1:0]             cli_rdata,
  output logic                           vram_rden,
  output logic [VRAM_AW-1:0]             vram_rdaddr,
  input  logic [VRAM_DW-1:0]             vram_rddata,
  output logic                           oob_err,
  output logic [1:0]                     oob_cli
);

  logic [3:0]         gnt;
  logic [1:0]         gnt_idx;
  logic               any_gnt;
  cli_e               sel_cli;
  logic [VRAM_AW-1:0] sel_offset;
  logic [VRAM_AW-1:0] sel_addr;
  logic               sel_oob;
  rd_tag_t            tag_q [0:RD_LAT];
  rd_tag_t            ret_tag;

  rr_arbiter4 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (cli_req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign cli_gnt    = gnt;
  assign any_gnt    = |gnt;
  assign sel_cli    = cli_e'(gnt_idx);
  assign sel_offset = cli_offset[gnt_idx];
  assign sel_addr   = region_base(sel_cli) + sel_offset;
  assign sel_oob    = (sel_offset >= region_size(sel_cli));

  // Issue stage: out-of-bounds grants still consume the slot but never touch VRAM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_rden   <= 1'b0;
      vram_rdaddr <= '0;
    end else begin
      vram_rden <= any_gnt && !sel_oob;
      if (any_gnt) begin
        vram_rdaddr <= sel_addr;
      end
    end
  end

  // Tag shift register aligned so the last stage coincides with VRAM read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: any_gnt, zero: sel_oob, cli: sel_cli};
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Latch only the first out-of-bounds offender since reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oob_err <= 1'b0;
      oob_cli <= '0;
    end else if (any_gnt && sel_oob && !oob_err) begin
      oob_err <= 1'b1;
      oob_cli <= gnt_idx;
    end
  end

  assign ret_tag = tag_q[RD_LAT];

  // Steer the return strobe to the originator; data is zeroed for OOB reads and while idle
  always_comb begin
    cli_rvalid = '0;
    cli_rdata  = '0;
    if (ret_tag.valid) begin
      cli_rvalid[ret_tag.cli] = 1'b1;
      if (!ret_tag.zero) begin
        cli_rdata = vram_rddata;
      end
    end
  end

endmodule

// File: tb/tb_vram_rd_arbiter.sv
module tb_vram_rd_arbiter;

  localparam int LAT_A = 2;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A: default latency
  logic [3:0]       req_a;
  logic [3:0][12:0] off_a;
  logic [3:0]       gnt_a, rv_a;
  logic [63:0]      rdata_a, vdata_a;
  logic             rden_a, err_a;
  logic [12:0]      addr_a;
  logic [1:0]       ocli_a;

  // DUT B: RD_LAT=4
  logic [3:0]       req_b;
  logic [3:0][12:0] off_b;
  logic [3:0]       gnt_b, rv_b;
  logic [63:0]      rdata_b, vdata_b;
  logic             rden_b, err_b;
  logic [12:0]      addr_b;
  logic [1:0]       ocli_b;

  vram_rd_arbiter #(.RD_LAT(LAT_A), .NCLI(4)) dut_a (
    .clk(clk), .reset(reset), .cli_req(req_a), .cli_offset(off_a), .cli_gnt(gnt_a),
    .cli_rvalid(rv_a), .cli_rdata(rdata_a), .vram_rden(rden_a), .vram_rdaddr(addr_a),
    .vram_rddata(vdata_a), .oob_err(err_a), .oob_cli(ocli_a)
  );

  vram_rd_arbiter #(.RD_LAT(LAT_B), .NCLI(4)) dut_b (
    .clk(clk), .reset(reset), .cli_req(req_b), .cli_offset(off_b), .cli_gnt(gnt_b),
    .cli_rvalid(rv_b), .cli_rdata(rdata_b), .vram_rden(rden_b), .vram_rdaddr(addr_b),
    .vram_rddata(vdata_b), .oob_err(err_b), .oob_cli(ocli_b)
  );

  // Memory contents are a function of the address so a misrouted read shows up
  function automatic logic [63:0] mw(input logic [12:0] a);
    return {16'hC0DE, 3'b000, a, 19'h5A5A5, a};
  endfunction

  // VRAM models: data valid RD_LAT cycles after the registered rden; garbage otherwise
  logic [13:0] pa [LAT_A];
  logic [13:0] pb [LAT_B];
  always @(posedge clk) begin
    pa[0] <= {rden_a, addr_a};
    for (int i = 1; i < LAT_A; i++) pa[i] <= pa[i-1];
    pb[0] <= {rden_b, addr_b};
    for (int i = 1; i < LAT_B; i++) pb[i] <= pb[i-1];
  end
  assign vdata_a = pa[LAT_A-1][13] ? mw(pa[LAT_A-1][12:0]) : 64'hBADB_ADBA_DBAD_BAD0;
  assign vdata_b = pb[LAT_B-1][13] ? mw(pb[LAT_B-1][12:0]) : 64'hBADB_ADBA_DBAD_BAD0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  cli;
    logic [12:0] off;
    logic [12:0] exp_addr;
    logic        exp_oob;
    logic        exp_err;
    logic [1:0]  exp_ocli;
  } vec_t;

  vec_t        vt [8];
  logic [12:0] base_t [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] eg;
    logic [3:0] erv;
    int         k;

    base_t[0] = 13'h0000; base_t[1] = 13'h0800; base_t[2] = 13'h1800; base_t[3] = 13'h1A00;
    vt[0] = '{2'd0, 13'h0005, 13'h0005, 1'b0, 1'b0, 2'd0};
    vt[1] = '{2'd2, 13'h0010, 13'h1810, 1'b0, 1'b0, 2'd0};
    vt[2] = '{2'd3, 13'h05FF, 13'h1FFF, 1'b0, 1'b0, 2'd0};
    vt[3] = '{2'd1, 13'h0FFF, 13'h17FF, 1'b0, 1'b0, 2'd0};
    vt[4] = '{2'd0, 13'h07FF, 13'h07FF, 1'b0, 1'b0, 2'd0};
    vt[5] = '{2'd1, 13'h1000, 13'h0000, 1'b1, 1'b1, 2'd1};
    vt[6] = '{2'd3, 13'h0600, 13'h0000, 1'b1, 1'b1, 2'd1};
    vt[7] = '{2'd2, 13'h0200, 13'h0000, 1'b1, 1'b1, 2'd1};

    reset = 1'b1;
    req_a = '0; off_a = '0;
    req_b = '0; off_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rden",  rden_a,  1'b0);
    chk("rst_addr",  addr_a,  13'h0);
    chk("rst_rv",    rv_a,    4'h0);
    chk("rst_rdata", rdata_a, 64'h0);
    chk("rst_err",   err_a,   1'b0);
    chk("rst_ocli",  ocli_a,  2'd0);
    chk("rst_gnt",   gnt_a,   4'h0);
    next_cyc();
    reset = 1'b0;
    next_cyc();

    // Table of single reads: translation, in-bounds edges, out-of-bounds and stickiness
    for (int v = 0; v < 8; v++) begin
      req_a = 4'b0001 << vt[v].cli;
      off_a[vt[v].cli] = vt[v].off;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", v), gnt_a, 4'b0001 << vt[v].cli);
      for (int c = 1; c <= LAT_A + 2; c++) begin
        next_cyc();
        if (c == 1) req_a = '0;
        @(negedge clk);
        if (c == 1) begin
          chk($sformatf("v%0d_gnt_idle", v), gnt_a, 4'h0);
          chk($sformatf("v%0d_rden", v), rden_a, !vt[v].exp_oob);
          if (!vt[v].exp_oob) chk($sformatf("v%0d_addr", v), addr_a, vt[v].exp_addr);
          chk($sformatf("v%0d_err", v), err_a, vt[v].exp_err);
          chk($sformatf("v%0d_ocli", v), ocli_a, vt[v].exp_ocli);
        end
        erv = (c == 1 + LAT_A) ? (4'b0001 << vt[v].cli) : 4'h0;
        chk($sformatf("v%0d_rv_c%0d", v, c), rv_a, erv);
        if (c == 1 + LAT_A)
          chk($sformatf("v%0d_rdata", v), rdata_a, vt[v].exp_oob ? 64'h0 : mw(vt[v].exp_addr));
      end
      next_cyc();
    end

    // Fairness: all four requesting continuously from reset
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) off_a[i] = 13'h0010 + 13'(i);
    req_a = 4'hF;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cyc();
      if (c == 8) req_a = '0;
      @(negedge clk);
      eg = (c < 8) ? (4'b0001 << (c % 4)) : 4'h0;
      chk($sformatf("rr_gnt_c%0d", c), gnt_a, eg);
      if (c >= 1 && c <= 8) begin
        k = (c - 1) % 4;
        chk($sformatf("rr_rden_c%0d", c), rden_a, 1'b1);
        chk($sformatf("rr_addr_c%0d", c), addr_a, base_t[k] + 13'h0010 + 13'(k));
      end
      if (c >= 3 && c < 11) begin
        k = (c - 3) % 4;
        chk($sformatf("rr_rv_c%0d", c), rv_a, 4'b0001 << k);
        chk($sformatf("rr_rdata_c%0d", c), rdata_a, mw(base_t[k] + 13'h0010 + 13'(k)));
      end else begin
        chk($sformatf("rr_rv_c%0d", c), rv_a, 4'h0);
      end
    end
    next_cyc();

    // Reset flush: tile read granted, reset the next cycle
    req_a = 4'b0001;
    off_a[0] = 13'h0003;
    @(negedge clk);
    chk("fl_gnt", gnt_a, 4'b0001);
    next_cyc();
    req_a = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("fl_rden",  rden_a,  1'b0);
    chk("fl_addr",  addr_a,  13'h0);
    chk("fl_rv",    rv_a,    4'h0);
    chk("fl_rdata", rdata_a, 64'h0);
    chk("fl_err",   err_a,   1'b0);
    chk("fl_ocli",  ocli_a,  2'd0);
    next_cyc();
    reset = 1'b0;
    for (int c = 2; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("fl_rv_c%0d", c), rv_a, 4'h0);
      next_cyc();
    end
    // Pointer must be back at tile: tile wins over pattern
    req_a = 4'b0011;
    off_a[1] = 13'h0004;
    @(negedge clk);
    chk("fl_ptr_gnt", gnt_a, 4'b0001);
    next_cyc();
    req_a = '0;
    repeat (5) next_cyc();

    // RD_LAT=4 build: single sprite read
    req_b = 4'b1000;
    off_b[3] = 13'h0123;
    @(negedge clk);
    chk("l4_gnt", gnt_b, 4'b1000);
    for (int c = 1; c <= 7; c++) begin
      next_cyc();
      if (c == 1) req_b = '0;
      @(negedge clk);
      if (c == 1) begin
        chk("l4_rden", rden_b, 1'b1);
        chk("l4_addr", addr_b, 13'h1B23);
      end
      chk($sformatf("l4_rv_c%0d", c), rv_b, (c == 5) ? 4'b1000 : 4'h0);
      if (c == 5) chk("l4_rdata", rdata_b, mw(13'h1B23));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
